// File: rtl/hi_lo_unit.sv
// hi_lo_unit: HI/LO register stage behind the ALU.
// Captures mult/div results on accept, holds them for a fixed latency,
// then commits them to HI/LO. Serves MTHI/MTLO writes and MFHI/MFLO reads,
// and stalls HI/LO requests that collide with an in-flight operation.

package hi_lo_pkg;
  typedef logic [5:0] funct_t;

  localparam funct_t FN_MFHI  = 6'h10;
  localparam funct_t FN_MTHI  = 6'h11;
  localparam funct_t FN_MFLO  = 6'h12;
  localparam funct_t FN_MTLO  = 6'h13;
  localparam funct_t FN_MULT  = 6'h18;
  localparam funct_t FN_MULTU = 6'h19;
  localparam funct_t FN_DIV   = 6'h1A;
  localparam funct_t FN_DIVU  = 6'h1B;
  localparam funct_t FN_ADDU  = 6'h21;
endpackage

module hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  funct_t      fncode,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_o,
  input  logic [31:0] rs_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] MULT_LAT_C = 4'(MULT_LATENCY);
  localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LATENCY);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  count_r;
  logic [31:0] pend_hi_r;
  logic [31:0] pend_lo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;

  logic        is_hilo_s;
  logic        is_muldiv_s;
  logic [3:0]  lat_s;
  logic [31:0] rd_data_s;

  // Decode the function code: HI/LO membership, mult/div class and its latency.
  always_comb begin
    is_hilo_s   = 1'b0;
    is_muldiv_s = 1'b0;
    lat_s       = 4'd0;
    case (fncode)
      FN_MULT, FN_MULTU: begin
        is_hilo_s   = 1'b1;
        is_muldiv_s = 1'b1;
        lat_s       = MULT_LAT_C;
      end
      FN_DIV, FN_DIVU: begin
        is_hilo_s   = 1'b1;
        is_muldiv_s = 1'b1;
        lat_s       = DIV_LAT_C;
      end
      FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO: begin
        is_hilo_s   = 1'b1;
      end
      default: begin
        is_hilo_s   = 1'b0;
        is_muldiv_s = 1'b0;
        lat_s       = 4'd0;
      end
    endcase
  end

  // Control FSM: accept mult/div or MTHI/MTLO in IDLE, count down and commit in BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= 4'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && is_muldiv_s) begin
            // Operands are only valid on the accept cycle, so capture now.
            pend_lo_r <= alu_r;
            pend_hi_r <= alu_o;
            count_r   <= lat_s;
            busy_r    <= 1'b1;
            state_r   <= ST_BUSY;
          end else if (start && (fncode == FN_MTHI)) begin
            hi_r <= rs_data;
          end else if (start && (fncode == FN_MTLO)) begin
            lo_r <= rs_data;
          end else begin
            count_r <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (count_r == 4'd1) begin
            hi_r    <= pend_hi_r;
            lo_r    <= pend_lo_r;
            count_r <= 4'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // MFHI/MFLO read mux; zero unless an unstalled read is being issued.
  always_comb begin
    rd_data_s = 32'd0;
    if (start && !busy_r) begin
      case (fncode)
        FN_MFHI: rd_data_s = hi_r;
        FN_MFLO: rd_data_s = lo_r;
        default: rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign hi      = hi_r;
  assign lo      = lo_r;
  assign busy    = busy_r;
  assign rd_data = rd_data_s;
  assign stall   = start & busy_r & is_hilo_s;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Self-checking bench for hi_lo_unit against a cycle-indexed reference model.
module tb_hi_lo_unit;
  import hi_lo_pkg::*;

  localparam int ML = 4;
  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  funct_t      fncode;
  logic [31:0] alu_r, alu_o, rs_data;
  logic [31:0] hi, lo, rd_data;
  logic        busy, stall;

  hi_lo_unit #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .fncode(fncode),
    .alu_r(alu_r), .alu_o(alu_o), .rs_data(rs_data),
    .hi(hi), .lo(lo), .rd_data(rd_data), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: absolute cycle index, first idle cycle after the op, values.
  int          cyc = 0;
  int          done_cyc = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  function automatic bit is_hilo_op(funct_t f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO};
  endfunction

  function automatic int lat_of(funct_t f);
    if (f inside {FN_MULT, FN_MULTU}) return ML;
    if (f inside {FN_DIV, FN_DIVU}) return DL;
    return 0;
  endfunction

  function automatic bit m_busy();
    return cyc < done_cyc;
  endfunction

  function automatic bit m_stall();
    return start && m_busy() && is_hilo_op(fncode);
  endfunction

  function automatic logic [31:0] m_rd();
    if (start && !m_busy() && fncode == FN_MFHI) return m_hi;
    if (start && !m_busy() && fncode == FN_MFLO) return m_lo;
    return 32'd0;
  endfunction

  task automatic model_tick();
    if (start && !m_busy()) begin
      if (lat_of(fncode) != 0) begin
        p_lo = alu_r;
        p_hi = alu_o;
        done_cyc = cyc + 1 + lat_of(fncode);
      end else if (fncode == FN_MTHI) begin
        m_hi = rs_data;
      end else if (fncode == FN_MTLO) begin
        m_lo = rs_data;
      end
    end
    cyc++;
    if (cyc == done_cyc) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
    done_cyc = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive(input logic st, input funct_t fn, input logic [31:0] r,
                       input logic [31:0] o, input logic [31:0] rs);
    start = st; fncode = fn; alu_r = r; alu_o = o; rs_data = rs;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
    drive(1'b1, FN_MFHI, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_mfhi: got %h expected %h", rd_data, 32'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick();
    drive(1'b1, FN_MFLO, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_mflo: got %h expected %h", rd_data, 32'h0); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tick();
  endtask

  task automatic test_mult();
    int busy_cnt = 0;
    drive(1'b1, FN_MULT, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'd0);
    @(negedge clk);
    n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL mult_accept_stall: got %b expected %b", stall, m_stall()); end
    tick();
    drive(1'b0, FN_ADDU, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL mult_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
      n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, m_hi); end
      n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, m_lo); end
      tick();
    end
    n_vec++; if (busy_cnt != ML) begin n_err++; $display("FAIL mult_busy_len: got %0d expected %0d", busy_cnt, ML); end
    n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_final_hi: got %h expected FFFFFFFF", hi); end
    n_vec++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_final_lo: got %h expected FFFFFFF1", lo); end
  endtask

  task automatic test_div_mflo();
    int  stall_cnt = 0;
    bit  released = 1'b0;
    drive(1'b1, FN_DIV, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0);
    tick();
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    tick();
    drive(1'b1, FN_MFLO, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 20 && !released; i++) begin
      @(negedge clk);
      n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL div_stall[%0d]: got %b expected %b", i, stall, m_stall()); end
      if (stall === 1'b1) stall_cnt++;
      else begin
        released = 1'b1;
        n_vec++; if (rd_data !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_mflo_rd: got %h expected FFFFFFFD", rd_data); end
      end
      tick();
    end
    n_vec++; if (!released) begin n_err++; $display("FAIL div_timeout: got stalled expected release"); end
    n_vec++; if (stall_cnt != DL - 1) begin n_err++; $display("FAIL div_stall_len: got %0d expected %0d", stall_cnt, DL - 1); end
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    bit released = 1'b0;
    drive(1'b1, FN_MTHI, 32'd0, 32'd0, 32'h12345678);
    tick();
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_vec++; if (hi !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    tick();
    lo_before = m_lo;
    drive(1'b1, FN_MULT, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd0);
    tick();
    drive(1'b1, FN_MTLO, 32'd0, 32'd0, 32'hCAFEF00D);
    for (int i = 0; i < 20 && !released; i++) begin
      @(negedge clk);
      n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL mtlo_stall[%0d]: got %b expected %b", i, stall, m_stall()); end
      n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL mtlo_lo[%0d]: got %h expected %h", i, lo, m_lo); end
      if (stall === 1'b1) begin
        n_vec++; if (lo !== lo_before) begin n_err++; $display("FAIL mtlo_lo_held[%0d]: got %h expected %h", i, lo, lo_before); end
      end else released = 1'b1;
      tick();
    end
    n_vec++; if (!released) begin n_err++; $display("FAIL mtlo_timeout: got stalled expected release"); end
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_vec++; if (lo !== 32'hCAFEF00D) begin n_err++; $display("FAIL mtlo_final_lo: got %h expected CAFEF00D", lo); end
    n_vec++; if (hi !== 32'h5A5A5A5A) begin n_err++; $display("FAIL mtlo_final_hi: got %h expected 5A5A5A5A", hi); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_hi, prev_lo;
    int upd = 0, stall_cnt = 0;
    bit accepted = 1'b0;
    @(negedge clk);
    prev_hi = hi; prev_lo = lo;
    drive(1'b1, FN_MULTU, 32'h11111111, 32'h22222222, 32'd0);
    tick();
    drive(1'b1, FN_DIVU, 32'h33333333, 32'h44444444, 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hi !== prev_hi || lo !== prev_lo) upd++;
      prev_hi = hi; prev_lo = lo;
      n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
      n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall, m_stall()); end
      if (stall === 1'b1) stall_cnt++;
      else if (start && !accepted) accepted = 1'b1;
      tick();
      if (accepted) drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    end
    n_vec++; if (stall_cnt != ML) begin n_err++; $display("FAIL b2b_stall_len: got %0d expected %0d", stall_cnt, ML); end
    n_vec++; if (upd != 2) begin n_err++; $display("FAIL b2b_updates: got %0d expected 2", upd); end
    n_vec++; if (hi !== 32'h44444444) begin n_err++; $display("FAIL b2b_hi: got %h expected 44444444", hi); end
    n_vec++; if (lo !== 32'h33333333) begin n_err++; $display("FAIL b2b_lo: got %h expected 33333333", lo); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, FN_MULT, 32'h00000077, 32'h00000088, 32'd0);
    tick();
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h expected 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h expected 0", lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL rstmid_post_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
      n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL rstmid_late_commit[%0d]: got %h/%h expected %h/%h", i, hi, lo, m_hi, m_lo); end
    end
    tick();
  endtask

  task automatic test_non_hilo();
    drive(1'b1, FN_MULTU, 32'h0BADF00D, 32'h00C0FFEE, 32'd0);
    tick();
    drive(1'b1, FN_ADDU, 32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++; if (stall !== 1'b0 || stall !== m_stall()) begin n_err++; $display("FAIL addu_stall[%0d]: got %b expected %b", i, stall, m_stall()); end
      n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL addu_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
      n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL addu_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, m_hi, m_lo); end
      tick();
    end
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_random();
    funct_t ops [9] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO, FN_ADDU};
    bit hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold)
        drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom);
      @(negedge clk);
      n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, stall, m_stall()); end
      n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
      n_vec++; if (rd_data !== m_rd()) begin n_err++; $display("FAIL rnd_rd[%0d]: got %h expected %h", i, rd_data, m_rd()); end
      n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL rnd_hi[%0d]: got %h expected %h", i, hi, m_hi); end
      n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL rnd_lo[%0d]: got %h expected %h", i, lo, m_lo); end
      hold = m_stall();
      tick();
    end
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, FN_ADDU, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_mult();
    test_div_mflo();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    test_non_hilo();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hi_lo_unit.md
# hi_lo_unit

Multi-cycle HI/LO register stage directly downstream of the ALU. Captures the ALU's low result `r` and high result `o` for MULT/MULTU/DIV/DIVU, holds them for a parameterised latency, then commits them to the architectural HI/LO registers. Serves MTHI/MTLO writes and MFHI/MFLO reads, and raises `stall` so the pipeline waits when a HI/LO access collides with an in-flight operation.

## Interface
One clock; reset is asynchronous and active-high.
- `MULT_LATENCY`, default 4: cycles from accept to commit for MULT/MULTU; legal range 1..15.
- `DIV_LATENCY`, default 8: cycles from accept to commit for DIV/DIVU; legal range 1..15.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: issue strobe; `fncode` is valid while it is high.
- `fncode` input funct_t: the instruction function code.
- `alu_r` input 32: ALU `r` output (product low word or quotient).
- `alu_o` input 32: ALU `o` output (product high word or remainder).
- `rs_data` input 32: source operand for MTHI/MTLO.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.
- `rd_data` output 32: MFHI/MFLO read data.
- `busy` output 1: a mult/div operation is in flight.
- `stall` output 1: the current `start` request was refused and must be held.

## Operation
- HI/LO op set is {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO}. `start` with any other `fncode` is ignored, with no stall and no state change.
- **State:**
  - `hi`, `lo`
  - `pend_hi`, `pend_lo`
  - 4-bit `count`
- **FSM:**
  - IDLE (`count==0`)
  - BUSY (`count!=0`)
- **IDLE, mult/div accepted** (`start` and MULT/MULTU/DIV/DIVU):
  - `pend_lo`←`alu_r`, `pend_hi`←`alu_o`.
  - `count`←the matching latency.
  - Next state is BUSY.
  - The ALU is combinational, so its operands are only guaranteed on the accept cycle, which is why the result is captured then.
- **BUSY:**
  - `count` decrements each edge.
  - On the edge where `count==1`: `hi`←`pend_hi`, `lo`←`pend_lo`, `count`←0, and the next state is IDLE.
- **MTHI / MTLO in IDLE:** `hi` (or `lo`) ←`rs_data` at that edge.
- **MFHI / MFLO:** `rd_data` is combinational, equal to `hi` (or `lo`) when `start` is high and `busy==0`. It is 0 otherwise.
- **`stall`:** `stall = start & busy & (fncode in HI/LO op set)`, combinational.
- **Stalled requests:** a stalled request has no effect. It does not restart the counter and does not write HI/LO. The requester holds `start`/`fncode` until `stall` falls.
- **`busy`:** equals `count!=0`, driven from the register with no combinational input path.
- **Commit vs. new request:** a request on the commit cycle still sees `busy=1` and is stalled. The new op is accepted on the following cycle. This forbids back-to-back overlap; there is never more than one op in flight.
- **Divide by zero:** HI/LO take whatever the ALU presents. The architectural result is unpredictable, and the block neither checks nor flags it.
- **Reset (asserted at any time, including mid-operation):**
  - `hi`, `lo`, `pend_*` and `count` go to 0.
  - The pending result is discarded.
  - `busy`=0, `stall`=0, `rd_data`=0.

## Timing
- Accept edge E0. Commit edge is E`L`, where L is the op's latency.
- `busy` is high in the L cycles after E0 and low from E`L` onward.
- New `hi`/`lo` values are visible in the cycle after E`L`.
- Example, L=1: accept at E0, `busy` high for one cycle, commit at E1.
- An MFHI issued during BUSY stalls until the first cycle with `busy=0`. It then reads the committed value in that same cycle, with zero added latency.
- MTHI/MTLO become visible on `hi`/`lo` the cycle after their edge.
- `stall` and `rd_data` are same-cycle combinational. `start` must be stable before the edge.
- The counter never wraps: it is loaded only from IDLE and stops at 0.

## Test plan
- Reset, then MFHI and MFLO → `rd_data`=0x00000000 both. `busy`=0.
- MULT with `alu_r`=0xFFFFFFF1, `alu_o`=0xFFFFFFFF (−3×5), MULT_LATENCY=4:
  - `busy` is high for exactly 4 cycles.
  - `lo`=0xFFFFFFF1 and `hi`=0xFFFFFFFF appear after E4.
  - `alu_*` change to 0xDEADBEEF after E0 and this has no effect.
- DIV with `alu_r`=0xFFFFFFFD, `alu_o`=0xFFFFFFFF (−7/2), then MFLO held from E0+1:
  - `stall`=1 for 7 cycles.
  - Then `rd_data`=0xFFFFFFFD with `stall`=0.
- MTHI `rs_data`=0x12345678 in IDLE → `hi`=0x12345678 next cycle. MTLO during BUSY → stalled, `lo` unchanged until commit.
- DIVU issued while MULTU is busy:
  - Stalled until MULTU commits.
  - Accepted on the next cycle and commits DIV_LATENCY later.
  - Exactly two HI/LO updates occur.
- Reset asserted asynchronously at count=2 mid-MULT:
  - `hi`=`lo`=0 and `busy`=0 immediately.
  - After release, no late commit occurs.
- Non-HI/LO `fncode` (ADDU) with `start` during BUSY → `stall`=0, state unchanged.
